// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes,
// ALU codes, datapath mux selects and the ALU-op decoder interface.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_LUI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR1,
        S_JALR2
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_XOR  = 3'd4;
    localparam logic [2:0] ALU_SLT  = 3'd5;
    localparam logic [2:0] ALU_SLTU = 3'd6;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REGA  = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_REGB = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // ALU-op decoder modes and branch-condition selects.
    localparam logic [1:0] MODE_MEM    = 2'd0;
    localparam logic [1:0] MODE_R      = 2'd1;
    localparam logic [1:0] MODE_I      = 2'd2;
    localparam logic [1:0] MODE_BRANCH = 2'd3;

    localparam logic [2:0] BR_NEVER = 3'd0;
    localparam logic [2:0] BR_ZERO  = 3'd1;
    localparam logic [2:0] BR_NZERO = 3'd2;
    localparam logic [2:0] BR_LT    = 3'd3;
    localparam logic [2:0] BR_BGE   = 3'd4;

    function automatic logic [2:0] imm_src_for(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_JALR, OP_ITYPE: imm_src_for = IMM_I;
            OP_STORE:                   imm_src_for = IMM_S;
            OP_BRANCH:                  imm_src_for = IMM_B;
            OP_JAL:                     imm_src_for = IMM_J;
            OP_LUI:                     imm_src_for = IMM_U;
            default:                    imm_src_for = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Maps instruction class plus funct3/funct7b5 to an ALUControl code and, for
// branches, the flag condition that decides whether the branch is taken.
module alu_op_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] mode_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    output logic [2:0] alu_control_o,
    output logic [2:0] br_cond_o
);

    // NOTE: every output gets a default before the case so no path infers a latch.
    always_comb begin
        alu_control_o = ALU_ADD;
        br_cond_o     = BR_NEVER;
        case (mode_i)
            MODE_R, MODE_I: begin
                case (funct3_i)
                    3'b000:  alu_control_o = (mode_i == MODE_R && funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b100:  alu_control_o = ALU_XOR;
                    3'b110:  alu_control_o = ALU_OR;
                    3'b111:  alu_control_o = ALU_AND;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b011:  alu_control_o = ALU_SLTU;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            MODE_BRANCH: begin
                // Signed compares run slt and test zero; unsigned ones use the ALU's lt/bge flags.
                case (funct3_i)
                    3'b000:  begin alu_control_o = ALU_SUB; br_cond_o = BR_ZERO;  end
                    3'b001:  begin alu_control_o = ALU_SUB; br_cond_o = BR_NZERO; end
                    3'b100:  begin alu_control_o = ALU_SLT; br_cond_o = BR_NZERO; end
                    3'b101:  begin alu_control_o = ALU_SLT; br_cond_o = BR_ZERO;  end
                    3'b110:  begin alu_control_o = ALU_SUB; br_cond_o = BR_LT;    end
                    3'b111:  begin alu_control_o = ALU_SUB; br_cond_o = BR_BGE;   end
                    default: begin alu_control_o = ALU_SUB; br_cond_o = BR_NEVER; end
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I datapath: sequences each instruction
// and drives all datapath selects, write enables and the ALU operation.
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       lt,
    input  logic       bge,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal
);

    state_e     state_q, state_d;
    logic [1:0] alu_mode;
    logic [2:0] br_cond;
    logic       branch_taken;

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        case (state_q)
            S_EXECR:  alu_mode = MODE_R;
            S_EXECI:  alu_mode = MODE_I;
            S_BRANCH: alu_mode = MODE_BRANCH;
            default:  alu_mode = MODE_MEM;
        endcase
    end

    alu_op_decoder u_alu_op_decoder (
        .mode_i        (alu_mode),
        .funct3_i      (funct3),
        .funct7b5_i    (funct7b5),
        .alu_control_o (ALUControl),
        .br_cond_o     (br_cond)
    );

    always_comb begin
        case (br_cond)
            BR_ZERO:  branch_taken = zero;
            BR_NZERO: branch_taken = ~zero;
            BR_LT:    branch_taken = lt;
            BR_BGE:   branch_taken = bge;
            default:  branch_taken = 1'b0;
        endcase
    end

    assign ImmSrc = imm_src_for(op);

    always_comb begin
        state_d   = state_q;
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_REGB;
        illegal   = 1'b0;

        case (state_q)
            S_FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_LUI:            state_d = S_LUI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR1;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_REGA;
                ALUSrcB = SRCB_IMM;
                state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_REGA;
                ALUSrcB = SRCB_REGB;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_REGA;
                ALUSrcB = SRCB_IMM;
                state_d = S_ALUWB;
            end
            S_LUI: begin
                ALUSrcA = SRCA_ZERO;
                ALUSrcB = SRCB_IMM;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc = RES_ALUOUT;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                // Target was computed into ALUOut during DECODE; the flags only gate the PC load.
                ALUSrcA   = SRCA_REGA;
                ALUSrcB   = SRCB_REGB;
                ResultSrc = RES_ALUOUT;
                PCWrite   = branch_taken;
                state_d   = S_FETCH;
            end
            S_JAL, S_JALR2: begin
                PCWrite   = 1'b1;
                ResultSrc = RES_ALUOUT;
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                state_d   = S_ALUWB;
            end
            S_JALR1: begin
                ALUSrcA = SRCA_REGA;
                ALUSrcB = SRCB_IMM;
                state_d = S_JALR2;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset parks the FSM in FETCH; suppress its writes until reset is released.
        if (rst) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
        end
    end

endmodule
